ps2_keycode_rx: RTL and testbench



---
 rtl/ps2_keycode_rx.sv | 132 +++++++++++++
 tb/tb_ps2_keycode_rx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: filters the raw clock, frames 11-bit bytes and
// turns make/break scan-code sequences into a held key code (0x00 = silence).
module ps2_keycode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] codigo,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] rx_byte
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BREAK     = 2'd1;
  localparam logic [1:0] ST_EXT       = 2'd2;
  localparam logic [1:0] ST_EXT_BREAK = 2'd3;

  logic          clk_s1_reg, clk_s2_reg, data_s1_reg, data_s2_reg;
  logic          filt_clk_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic [10:0]   shift_reg;
  logic [3:0]    bit_cnt_reg;
  logic [TW-1:0] tout_cnt_reg;
  logic [1:0]    state_reg;
  logic [7:0]    codigo_reg, rx_byte_reg;
  logic          code_valid_reg, frame_err_reg;

  logic          filt_flip;
  logic          fall_evt;
  logic [7:0]    frame_byte;
  logic          frame_ok;

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  assign filt_flip  = (clk_s2_reg != filt_clk_reg) && (filt_cnt_reg == FW'(FILTER_LEN - 1));
  assign fall_evt   = filt_flip && filt_clk_reg;
  assign frame_byte = shift_reg[8:1];
  assign frame_ok   = !shift_reg[0] && shift_reg[10] && (^shift_reg[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_reg   <= 1'b1;
      clk_s2_reg   <= 1'b1;
      data_s1_reg  <= 1'b1;
      data_s2_reg  <= 1'b1;
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= '0;
    end else begin
      clk_s1_reg  <= ps2_clk;
      clk_s2_reg  <= clk_s1_reg;
      data_s1_reg <= ps2_data;
      data_s2_reg <= data_s1_reg;
      if (clk_s2_reg == filt_clk_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_flip) begin
        filt_clk_reg <= clk_s2_reg;
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      tout_cnt_reg   <= '0;
      state_reg      <= ST_IDLE;
      codigo_reg     <= 8'h00;
      rx_byte_reg    <= 8'h00;
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      if (fall_evt || bit_cnt_reg == 4'd0) begin
        tout_cnt_reg <= '0;
      end else begin
        tout_cnt_reg <= tout_cnt_reg + 1'b1;
      end

      if (bit_cnt_reg == 4'd11) begin
        bit_cnt_reg <= 4'd0;
        if (frame_ok) begin
          code_valid_reg <= 1'b1;
          rx_byte_reg    <= frame_byte;
          case (state_reg)
            ST_IDLE: begin
              if (frame_byte == 8'hF0) begin
                state_reg <= ST_BREAK;
              end else if (frame_byte == 8'hE0) begin
                state_reg <= ST_EXT;
              end else begin
                codigo_reg <= frame_byte;
              end
            end
            ST_BREAK: begin
              if (frame_byte == codigo_reg) codigo_reg <= 8'h00;
              state_reg <= ST_IDLE;
            end
            ST_EXT: begin
              state_reg <= (frame_byte == 8'hF0) ? ST_EXT_BREAK : ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
          endcase
        end else begin
          frame_err_reg <= 1'b1;
        end
      end else if (fall_evt) begin
        shift_reg   <= {data_s2_reg, shift_reg[10:1]};
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
      end else if (bit_cnt_reg != 4'd0 && tout_cnt_reg == TW'(TIMEOUT_CYCLES)) begin
        // Abandoned partial frame: resynchronise silently on the next start bit.
        bit_cnt_reg <= 4'd0;
      end
    end
  end

  assign codigo     = codigo_reg;
  assign code_valid = code_valid_reg;
  assign frame_err  = frame_err_reg;
  assign rx_byte    = rx_byte_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames bit by bit and checks
// held code, raw byte and pulse counts against hand-computed values.
module tb_ps2_keycode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 40;   // PS/2 half period in clk cycles (scaled down)

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] codigo, rx_byte;
  logic       code_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;

  ps2_keycode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .codigo(codigo), .code_valid(code_valid), .frame_err(frame_err), .rx_byte(rx_byte)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the first nbits of the frame for byte b (parity optionally inverted).
  task automatic send(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      cycles(HALF);
      ps2_clk = 1'b0;
      cycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cycles(HALF);
  endtask

  task automatic frame(input logic [7:0] b);
    send(b, 1'b0, 11);
  endtask

  int cv0, fe0;

  initial begin
    cycles(4);
    @(negedge clk);
    chk("reset codigo", codigo, 8'h00);
    chk("reset rx_byte", rx_byte, 8'h00);
    chk("reset code_valid", code_valid, 0);
    chk("reset frame_err", frame_err, 0);
    @(posedge clk); #1 reset = 1'b0;
    cycles(20);

    cv0 = cv_cnt; fe0 = fe_cnt;
    frame(8'h15);
    chk("0x15 cv pulses", cv_cnt - cv0, 1);
    chk("0x15 rx_byte", rx_byte, 8'h15);
    chk("0x15 codigo", codigo, 8'h15);
    chk("0x15 no err", fe_cnt - fe0, 0);

    frame(8'hF0);
    chk("break prefix codigo held", codigo, 8'h15);
    frame(8'h15);
    chk("release codigo", codigo, 8'h00);
    chk("three cv pulses", cv_cnt - cv0, 3);

    frame(8'h15); frame(8'h1D); frame(8'hF0); frame(8'h15);
    chk("non-held release codigo", codigo, 8'h1D);
    chk("rx_byte last", rx_byte, 8'h15);

    cv0 = cv_cnt; fe0 = fe_cnt;
    send(8'h24, 1'b1, 11);
    chk("bad parity err", fe_cnt - fe0, 1);
    chk("bad parity no cv", cv_cnt - cv0, 0);
    chk("bad parity codigo", codigo, 8'h1D);
    chk("bad parity rx_byte", rx_byte, 8'h15);
    frame(8'h24);
    chk("good 0x24 codigo", codigo, 8'h24);

    fe0 = fe_cnt;
    send(8'h2D, 1'b0, 5);
    cycles(TIMEOUT + 500);
    frame(8'h2D);
    chk("timeout no err", fe_cnt - fe0, 0);
    chk("timeout codigo", codigo, 8'h2D);

    frame(8'h16);
    chk("codigo 0x16", codigo, 8'h16);
    send(8'h2D, 1'b0, 5);
    @(posedge clk); #1 reset = 1'b1;
    cycles(3);
    @(negedge clk);
    chk("mid reset codigo", codigo, 8'h00);
    chk("mid reset rx_byte", rx_byte, 8'h00);
    chk("mid reset cv", code_valid, 0);
    chk("mid reset fe", frame_err, 0);
    @(posedge clk); #1 reset = 1'b0;
    cycles(20);
    fe0 = fe_cnt;
    frame(8'h2D);
    chk("after reset codigo", codigo, 8'h2D);
    chk("after reset no err", fe_cnt - fe0, 0);

    frame(8'hE0); frame(8'h75);
    chk("E0 75 codigo", codigo, 8'h2D);
    frame(8'hE0); frame(8'hF0); frame(8'h75);
    chk("E0 F0 75 codigo", codigo, 8'h2D);
    frame(8'h3C);
    chk("after ext codigo", codigo, 8'h3C);

    fe0 = fe_cnt;
    @(posedge clk); #1 ps2_clk = 1'b0;
    cycles(2);
    #1 ps2_clk = 1'b1;
    cycles(50);
    frame(8'h33);
    chk("glitch codigo", codigo, 8'h33);
    chk("glitch no err", fe_cnt - fe0, 0);
    chk("glitch rx_byte", rx_byte, 8'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
